// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU step/run execution controller:
// controller state encoding, run-rate offset and default widths.
package cpu_ctrl_pkg;

    // Run period is 2^(rate + RATE_OFS) board clock cycles
    localparam int RATE_OFS  = 8;
    localparam int DEF_DIV_W = 24;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_e;

endpackage

// File: rtl/cpu_step_ctrl_key_edge.sv
// key_edge: rising-edge detector for a debounced key level.
// The previous-value register resets to 1 so that a key held through
// reset is not mistaken for a fresh press.
module key_edge (
    input  logic clk_i,
    input  logic srst_i,
    input  logic key_i,
    output logic rise_o
);

    logic prev_q;

    // Track the key level from the previous cycle
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= key_i;
        end
    end

    assign rise_o = key_i & ~prev_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns step/run keys into one-cycle CPU clock-enable
// pulses (single-step or free-run at 2^(rate+8) cycles per pulse) and
// counts issued pulses.
// Optional feature: define CPU_STEP_OF_TRAP_EN to halt in TRAP when the
// CPU reports overflow the cycle after a pulse; a step press leaves TRAP.
module cpu_step_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             step,
    input  logic             run,
    input  logic [3:0]       rate,
    input  logic             ofa,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] icount
);

    logic             step_rise;
    logic             run_rise;
    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] term_cnt;
    logic             div_done;
    logic             cpu_en_q;
    logic             running_q;
    logic             halted_q;
    logic [CNT_W-1:0] icount_q;
    logic             trap_hit;

    key_edge u_step_edge (
        .clk_i  (clka),
        .srst_i (rsta),
        .key_i  (step),
        .rise_o (step_rise)
    );

    key_edge u_run_edge (
        .clk_i  (clka),
        .srst_i (rsta),
        .key_i  (run),
        .rise_o (run_rise)
    );

    // Terminal count follows rate live; ">=" lets a shortened period
    // terminate immediately when the divider is already past it.
    assign term_cnt = (DIV_W'(1) << (32'(rate) + RATE_OFS)) - DIV_W'(1);
    assign div_done = (div_q >= term_cnt);

`ifdef CPU_STEP_OF_TRAP_EN
    logic ofa_chk_q;

    // Marks the cycle in which the CPU overflow flag is meaningful
    always_ff @(posedge clka) begin
        if (rsta) begin
            ofa_chk_q <= 1'b0;
        end else begin
            ofa_chk_q <= cpu_en_q;
        end
    end

    assign trap_hit = ofa_chk_q & ofa;
`else
    logic unused_ofa;
    assign unused_ofa = ofa;
    assign trap_hit   = 1'b0;
`endif

    // Controller FSM with divider, pulse and instruction counter
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            icount_q  <= '0;
        end else begin
            cpu_en_q <= 1'b0;
            if (trap_hit) begin
                state_q   <= ST_TRAP;
                running_q <= 1'b0;
                halted_q  <= 1'b1;
                div_q     <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // Run press wins over a simultaneous step press
                        if (run_rise) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                            div_q     <= '0;
                        end else if (step_rise) begin
                            cpu_en_q <= 1'b1;
                            icount_q <= icount_q + CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        // Stopping discards a coinciding terminal count
                        if (run_rise) begin
                            state_q   <= ST_IDLE;
                            running_q <= 1'b0;
                            div_q     <= '0;
                        end else if (div_done) begin
                            div_q    <= '0;
                            cpu_en_q <= 1'b1;
                            icount_q <= icount_q + CNT_W'(1);
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
`ifdef CPU_STEP_OF_TRAP_EN
                    ST_TRAP: begin
                        if (step_rise) begin
                            state_q  <= ST_IDLE;
                            halted_q <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                        halted_q  <= 1'b0;
                        div_q     <= '0;
                    end
                endcase
            end
        end
    end

    assign cpu_en  = cpu_en_q;
    assign running = running_q;
    assign halted  = halted_q;
    assign icount  = icount_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed testbench for cpu_step_ctrl. Cycle k is the interval after
// the k-th rising clock edge; inputs change 1 time unit after an edge.
module tb_cpu_step_ctrl;

    localparam int TB_CNT_W = 10;

    logic                clka;
    logic                rsta;
    logic                step;
    logic                run;
    logic [3:0]          rate;
    logic                ofa;
    logic                cpu_en;
    logic                running;
    logic                halted;
    logic [TB_CNT_W-1:0] icount;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulse_cyc[$];

    cpu_step_ctrl #(
        .DIV_W (24),
        .CNT_W (TB_CNT_W)
    ) dut (
        .clka    (clka),
        .rsta    (rsta),
        .step    (step),
        .run     (run),
        .rate    (rate),
        .ofa     (ofa),
        .cpu_en  (cpu_en),
        .running (running),
        .halted  (halted),
        .icount  (icount)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    always @(posedge clka) cyc <= cyc + 1;

    // Record the cycle of every cpu_en pulse
    always @(negedge clka) begin
        if (cpu_en === 1'b1) pulse_cyc.push_back(cyc);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", tag, got, cyc);
        end
    endtask

    task automatic go_to(input int target);
        while (cyc < target) begin
            @(posedge clka);
            #1;
        end
    endtask

    function automatic int pulse_at(input int idx);
        if (idx < pulse_cyc.size()) return pulse_cyc[idx];
        return -1;
    endfunction

    initial begin
        rsta = 1'b1;
        step = 1'b1;
        run  = 1'b0;
        rate = 4'd0;
        ofa  = 1'b0;

        // Reset with step held high
        go_to(3);
        rsta = 1'b0;
        check_val("rst_cpu_en", 32'(cpu_en), 32'd0);
        check_val("rst_running", 32'(running), 32'd0);
        check_val("rst_halted", 32'(halted), 32'd0);
        check_val("rst_icount", 32'(icount), 32'd0);
        pulse_cyc.delete();
        go_to(8);
        check_val("held_step_no_pulse", 32'(pulse_cyc.size()), 32'd0);
        step = 1'b0;

        // Single step: press at 10, pulse at 11 only
        go_to(10);
        step = 1'b1;
        go_to(15);
        step = 1'b0;
        check_val("step_pulses", 32'(pulse_cyc.size()), 32'd1);
        check_val("step_pulse_cyc", 32'(pulse_at(0)), 32'd11);
        check_val("step_icount", 32'(icount), 32'd1);

        // Free run at rate 0 from a run edge at 20
        pulse_cyc.delete();
        go_to(20);
        check_val("idle_running", 32'(running), 32'd0);
        run = 1'b1;
        go_to(21);
        run = 1'b0;
        check_val("run_running", 32'(running), 32'd1);
        check_val("run_no_early_pulse", 32'(cpu_en), 32'd0);
        go_to(790);
        check_val("run_pulses", 32'(pulse_cyc.size()), 32'd3);
        check_val("run_pulse0", 32'(pulse_at(0)), 32'd277);
        check_val("run_pulse1", 32'(pulse_at(1)), 32'd533);
        check_val("run_pulse2", 32'(pulse_at(2)), 32'd789);

        // Stop exactly on the terminal-count cycle 1044
        go_to(1044);
        run = 1'b1;
        go_to(1045);
        run = 1'b0;
        check_val("stop_running", 32'(running), 32'd0);
        check_val("stop_no_pulse", 32'(cpu_en), 32'd0);
        go_to(1645);
        check_val("stop_pulses", 32'(pulse_cyc.size()), 32'd3);
        check_val("stop_icount", 32'(icount), 32'd4);

        // Rate shortened while divider is past the new terminal count
        pulse_cyc.delete();
        rate = 4'd1;
        go_to(1700);
        run = 1'b1;
        go_to(1701);
        run = 1'b0;
        go_to(2000);
        rate = 4'd0;
        go_to(2260);
        check_val("rate_pulses", 32'(pulse_cyc.size()), 32'd2);
        check_val("rate_pulse0", 32'(pulse_at(0)), 32'd2001);
        check_val("rate_pulse1", 32'(pulse_at(1)), 32'd2257);
        go_to(2270);
        run = 1'b1;
        go_to(2271);
        run = 1'b0;
        check_val("rate_stop_running", 32'(running), 32'd0);
        check_val("rate_icount", 32'(icount), 32'd6);
        go_to(2600);
        check_val("idle_no_pulses", 32'(pulse_cyc.size()), 32'd2);

        // Step and run pressed together in IDLE
        pulse_cyc.delete();
        go_to(2610);
        step = 1'b1;
        run  = 1'b1;
        go_to(2611);
        step = 1'b0;
        run  = 1'b0;
        check_val("both_running", 32'(running), 32'd1);
        check_val("both_no_pulse", 32'(cpu_en), 32'd0);
        go_to(2700);
        check_val("both_pulses", 32'(pulse_cyc.size()), 32'd0);

        // Overflow the cycle after the 3rd pulse (pulses 2867, 3123, 3379)
        go_to(3380);
        check_val("of_pulses_before", 32'(pulse_cyc.size()), 32'd3);
        ofa = 1'b1;
        go_to(3381);
        ofa = 1'b0;
`ifdef CPU_STEP_OF_TRAP_EN
        check_val("trap_halted", 32'(halted), 32'd1);
        check_val("trap_running", 32'(running), 32'd0);
        go_to(5381);
        check_val("trap_no_pulses", 32'(pulse_cyc.size()), 32'd3);
        go_to(5390);
        step = 1'b1;
        go_to(5391);
        step = 1'b0;
        check_val("trap_exit_halted", 32'(halted), 32'd0);
        check_val("trap_exit_cpu_en", 32'(cpu_en), 32'd0);
        check_val("trap_exit_running", 32'(running), 32'd0);
        go_to(5450);
        check_val("trap_exit_pulses", 32'(pulse_cyc.size()), 32'd3);
        check_val("trap_icount", 32'(icount), 32'd9);
`else
        check_val("of_ign_halted", 32'(halted), 32'd0);
        check_val("of_ign_running", 32'(running), 32'd1);
        go_to(3640);
        check_val("of_ign_pulses", 32'(pulse_cyc.size()), 32'd4);
        check_val("of_ign_pulse3", 32'(pulse_at(3)), 32'd3635);
        go_to(3700);
        run = 1'b1;
        go_to(3701);
        run = 1'b0;
        check_val("of_ign_stop", 32'(running), 32'd0);
        check_val("of_ign_icount", 32'(icount), 32'd10);
`endif

        // Reset on the terminal-count cycle of a run
        pulse_cyc.delete();
        go_to(6000);
        run = 1'b1;
        go_to(6001);
        run = 1'b0;
        go_to(6100);
        check_val("mid_running", 32'(running), 32'd1);
        go_to(6256);
        rsta = 1'b1;
        go_to(6257);
        rsta = 1'b0;
        check_val("mid_rst_cpu_en", 32'(cpu_en), 32'd0);
        check_val("mid_rst_running", 32'(running), 32'd0);
        check_val("mid_rst_halted", 32'(halted), 32'd0);
        check_val("mid_rst_icount", 32'(icount), 32'd0);
        go_to(6600);
        check_val("mid_rst_no_pulses", 32'(pulse_cyc.size()), 32'd0);

        // Fill the counter with step presses, then wrap it
        pulse_cyc.delete();
        for (int i = 0; i < (1 << TB_CNT_W) - 1; i++) begin
            go_to(7000 + 2 * i);
            step = 1'b1;
            go_to(7001 + 2 * i);
            step = 1'b0;
        end
        go_to(9046);
        check_val("fill_pulses", 32'(pulse_cyc.size()), 32'd1023);
        check_val("fill_icount", 32'(icount), 32'd1023);
        go_to(9050);
        step = 1'b1;
        go_to(9051);
        step = 1'b0;
        check_val("wrap_cpu_en", 32'(cpu_en), 32'd1);
        check_val("wrap_icount", 32'(icount), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Execution controller for the single-cycle R/I CPU on the board. It turns debounced step/run keys into one-cycle clock-enable pulses for the CPU, so the CPU runs from the board clock instead of a key-derived clock. It supports single-step, free-run at a selectable rate, and optional halt-on-overflow. It also counts issued instructions for the LED display path.

## Interface
Parameters:
- DIV_W, 24, run-rate prescaler width
- CNT_W, 16, instruction counter width

Ports:
- clka  in  1  board clock; the only clock
- rsta  in  1  reset, synchronous, active-high
- step  in  1  debounced step key, level
- run  in  1  debounced run/stop key, level; each press toggles run/stop
- rate  in  4  run period select: period = 2^(rate+8) clka cycles
- ofa  in  1  CPU overflow flag, valid the cycle after a cpu_en pulse
- cpu_en  out  1  one-cycle CPU clock enable
- running  out  1  high while in RUN
- halted  out  1  high while in TRAP
- icount  out  CNT_W  number of cpu_en pulses issued

## Operation
- Edge detect: step_q and run_q register the key inputs. A rising edge means key=1 and its _q=0. On reset both _q registers load 1, so a key held through reset produces no edge.
- States: IDLE, RUN, TRAP (TRAP exists only with the macro). Reset state is IDLE.
- IDLE:
  - step edge: cpu_en=1 next cycle; stay in IDLE.
  - run edge: go to RUN and clear the divider.
  - step and run edges in the same cycle: run wins, and no step pulse is issued.
- RUN:
  - divider counts 0 .. period-1. At the terminal count: cpu_en=1 next cycle and divider returns to 0.
  - step edges are ignored.
  - run edge: go to IDLE. The pending count is discarded and no pulse is issued that cycle, even if the terminal count coincides.
- rate changes are sampled at every terminal-count comparison and take effect on the current count. If the divider is already ≥ the new period-1, it terminates on the next cycle.
- icount increments by 1 on every cpu_en and wraps from 2^CNT_W-1 to 0.
- Arithmetic: the divider is DIV_W bits. rate=15 gives period 2^23, which fits in the default width.

## Timing
- Reset values: cpu_en=0, running=0, halted=0, icount=0, divider=0, state=IDLE.
- All outputs are registered.
- Step latency: step first sampled high in cycle n gives cpu_en high in cycle n+1, for exactly 1 cycle.
- Run: a run edge in cycle e gives running=1 in cycle e+1 and the first cpu_en in cycle e+period+1. After that, pulses are exactly period cycles apart.
- running falls in the cycle after the stopping run edge.
- rsta asserted in any state, including mid-period or in the same cycle as a pulse, forces the reset values in the next cycle. No cpu_en is emitted in that cycle.

## Configuration
- Macro: CPU_STEP_OF_TRAP_EN.
- With the macro defined:
  - If ofa=1 in the cycle after any cpu_en, go to TRAP in the next cycle: halted=1, running=0, divider cleared, no further cpu_en.
  - In TRAP, a step edge returns to IDLE (halted=0) without issuing a pulse. run edges are ignored.
- Without the macro: there is no TRAP state, ofa is unused, and halted is tied to 0.

## Structure
- Shared package cpu_ctrl_pkg holds the state enum (IDLE/RUN/TRAP), the rate-offset constant 8, and the default DIV_W/CNT_W.
- Sub-module key_edge: registered rising-edge detector with a reset-to-1 previous register. It is instantiated twice, for step and run.

## Test plan
- Reset with step held high, then release and press step → exactly one cpu_en, 1 cycle after the press; icount=1.
- Run edge at cycle 10 with rate=0 → cpu_en at cycles 267, 523, 779; running=1 from cycle 11.
- In RUN, a run edge exactly at a terminal-count cycle → no pulse, running=0 the next cycle, icount unchanged.
- Step and run edges in the same cycle in IDLE → RUN entered, no immediate cpu_en.
- With CPU_STEP_OF_TRAP_EN, ofa=1 after the 3rd pulse → halted=1, no more pulses for 2000 cycles; a step edge then clears halted and issues no pulse.
- Preset icount to 16'hFFFF via 65535 fast pulses (rate=0), then one more pulse → icount=0; rsta mid-period → all outputs 0 the next cycle.
